// File: rtl/draw_sprite_anim.sv
`default_nettype none
`ifndef BUS_WIDTH
`define BUS_WIDTH 37
`endif
// ============================================================================
//  Module   : draw_sprite_anim
//  Brief    : Animated, runtime-positioned sprite overlay with a 2-cycle pipeline.
//             ROM content is a generated pattern: ((row << 4) + col) ^ FILE, and 0
//             outside FILE_X x FILE_Y.
//  Revision : 1.0
// ============================================================================
module draw_sprite_anim #(
    parameter int          WIDTH        = 48,
    parameter int          HEIGHT       = 64,
    parameter int          FRAMES       = 4,
    parameter int          ADDR_WIDTH_X = 6,
    parameter int          ADDR_WIDTH_Y = 8,
    parameter int          SCALE_X_BITS = 0,
    parameter int          SCALE_Y_BITS = 0,
    parameter int          TRANSPARENCY = 1,
    parameter logic [11:0] ALPHA        = 12'h000,
    parameter int          FRAME_DIV    = 8,
    parameter int          FILE         = 0,
    parameter int          FILE_X       = WIDTH,
    parameter int          FILE_Y       = FRAMES * HEIGHT
) (
    input  logic                                      pclk,
    input  logic                                      rst,
    input  logic [`BUS_WIDTH:0]                       video_bus_in,
    output logic [`BUS_WIDTH:0]                       video_bus_out,
    input  logic [10:0]                               xpos,
    input  logic [10:0]                               ypos,
    input  logic                                      visible,
    input  logic                                      mirror,
    input  logic                                      anim_en,
    input  logic                                      anim_oneshot,
    input  logic                                      anim_restart,
    output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] frame_idx,
    output logic                                      anim_done,
    output logic                                      sprite_px
);

    localparam int c_FI_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int c_DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int c_RGB_W  = 12;
    localparam int c_VBLNK  = 12;
    localparam int c_HBLNK  = 13;
    localparam int c_VC_LSB = 16;
    localparam int c_HC_LSB = 27;
    localparam logic [11:0]        c_RECT_W   = 12'(WIDTH << SCALE_X_BITS);
    localparam logic [11:0]        c_RECT_H   = 12'(HEIGHT << SCALE_Y_BITS);
    localparam logic [c_FI_W-1:0]  c_LAST     = c_FI_W'(FRAMES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(FRAME_DIV - 1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_FI_W-1:0]    w_frame_nxt;
    logic                 w_done_nxt;
    logic [c_DIV_W-1:0]   r_div_cnt, w_div_nxt;
    logic                 r_vblnk_prev;
    logic                 w_vbs, w_div_hit, w_step;
    logic [10:0]          r_xpos_l, r_ypos_l;
    logic                 r_vis_l, r_mir_l;

    assign w_vbs     = video_bus_in[c_VBLNK] & ~r_vblnk_prev;
    assign w_div_hit = (r_div_cnt == c_DIV_LAST);
    assign w_step    = w_vbs & anim_en & w_div_hit;

    // Frame-rate controls: shadows and the sequencer only move at vblank start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
            r_xpos_l     <= '0;
            r_ypos_l     <= '0;
            r_vis_l      <= 1'b0;
            r_mir_l      <= 1'b0;
            r_state      <= S_RUN;
            frame_idx    <= '0;
            anim_done    <= 1'b0;
            r_div_cnt    <= '0;
        end else begin
            r_vblnk_prev <= video_bus_in[c_VBLNK];
            if (w_vbs) begin
                r_xpos_l <= xpos;
                r_ypos_l <= ypos;
                r_vis_l  <= visible;
                r_mir_l  <= mirror;
            end
            r_state   <= w_state_nxt;
            frame_idx <= w_frame_nxt;
            anim_done <= w_done_nxt;
            r_div_cnt <= w_div_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = frame_idx;
        w_done_nxt  = anim_done;
        w_div_nxt   = r_div_cnt;
        if (w_vbs && anim_en) begin
            w_div_nxt = w_div_hit ? '0 : r_div_cnt + c_DIV_W'(1);
        end
        case (r_state)
            S_RUN: begin
                if (w_step) begin
                    if (frame_idx == c_LAST) begin
                        if (anim_oneshot) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_frame_nxt = '0;
                        end
                    end else begin
                        w_frame_nxt = frame_idx + c_FI_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (w_step && !anim_oneshot) begin
                    w_state_nxt = S_RUN;
                    w_frame_nxt = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
        if (anim_restart) begin
            w_state_nxt = S_RUN;
            w_frame_nxt = '0;
            w_done_nxt  = 1'b0;
            w_div_nxt   = '0;
        end
    end

    // Stage 1: hit test and ROM address generation from the live bus.
    logic [11:0]             w_dx, w_dy, w_col_raw, w_col, w_row;
    logic                    w_in_rect;
    logic [ADDR_WIDTH_X-1:0] w_rom_col;
    logic [ADDR_WIDTH_Y-1:0] w_rom_row;
    logic [11:0]             w_rom_px;
    logic                    w_unused_addr_hi;

    assign w_dx      = {1'b0, video_bus_in[c_HC_LSB +: 11]} - {1'b0, r_xpos_l};
    assign w_dy      = {1'b0, video_bus_in[c_VC_LSB +: 11]} - {1'b0, r_ypos_l};
    assign w_in_rect = ~w_dx[11] & ~w_dy[11] & (w_dx < c_RECT_W) & (w_dy < c_RECT_H);
    assign w_col_raw = w_dx >> SCALE_X_BITS;
    assign w_col     = r_mir_l ? (12'(WIDTH - 1) - w_col_raw) : w_col_raw;
    assign w_row     = 12'(frame_idx) * 12'(HEIGHT) + (w_dy >> SCALE_Y_BITS);
    assign w_rom_col = w_col[ADDR_WIDTH_X-1:0];
    assign w_rom_row = w_row[ADDR_WIDTH_Y-1:0];
    // Address bits above the ROM size are dropped by design.
    assign w_unused_addr_hi = &{1'b0, w_col[11:ADDR_WIDTH_X], w_row[11:ADDR_WIDTH_Y]};

    always_comb begin
        w_rom_px = '0;
        if ((int'(w_rom_col) < FILE_X) && (int'(w_rom_row) < FILE_Y)) begin
            w_rom_px = ((12'(w_rom_row) << 4) + 12'(w_rom_col)) ^ 12'(FILE);
        end
    end

    // Stage 2: synchronous ROM data meets the delayed bus in the output mux.
    logic [`BUS_WIDTH:0] r_bus1;
    logic                r_hit1;
    logic [11:0]         r_rom_q;
    logic                w_transparent, w_draw;

    assign w_transparent = (TRANSPARENCY != 0) && (r_rom_q == ALPHA);
    assign w_draw        = r_hit1 & ~r_bus1[c_HBLNK] & ~r_bus1[c_VBLNK] & ~w_transparent;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_bus1        <= '0;
            r_hit1        <= 1'b0;
            r_rom_q       <= '0;
            video_bus_out <= '0;
            sprite_px     <= 1'b0;
        end else begin
            r_bus1        <= video_bus_in;
            r_hit1        <= r_vis_l & w_in_rect;
            r_rom_q       <= w_rom_px;
            video_bus_out <= {r_bus1[`BUS_WIDTH:c_RGB_W], w_draw ? r_rom_q : r_bus1[c_RGB_W-1:0]};
            sprite_px     <= w_draw;
        end
    end

endmodule
`default_nettype wire
